pipeline_hold_ctrl: RTL

//  Consumes hazard requests (load-use Stall, EX-stage branch mispredict, multi-cycle data-memory wait)
//  and drives per-stage enables and flush controls for the 5-stage pipeline registers.

---
 rtl/pipeline_hold_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hold_ctrl.sv
// Pipeline hold/flush sequencer: turns hazard requests into per-stage enables and flushes,
// sequences memory-wait freezes and one-cycle post-mispredict flushes, keeps saturating perf counters.
//
// state    | meaning
// RUN      | normal issue; load-use stalls handled in place
// MEM_WAIT | pipeline frozen until data memory completes
// FLUSH    | one cycle after a mispredict; stall and mispredict masked
// ERROR    | memory wait timed out; frozen until reset
module pipeline_hold_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             Mispredict_EX,
    input  logic [1:0]       DMC_MEM,
    input  logic             DMEM_Ready,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IDEX_EN,
    output logic             EXMEM_EN,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             MEMWB_BUBBLE,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_MEM_WAIT = 2'b01,
        S_FLUSH    = 2'b10,
        S_ERROR    = 2'b11
    } state_t;

    localparam int                WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              mem_wait;
    logic              pc_en, ifid_en, idex_en, exmem_en;
    logic              ifid_flush, idex_flush, memwb_bubble;
    logic              flush_inc, stall_inc;

    assign mem_wait = (DMC_MEM != 2'b00) && !DMEM_Ready;

    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        flush_inc    = 1'b0;

        case (state)
            S_RUN, S_MEM_WAIT: begin
                // A frozen pipeline keeps the same instructions, so once memory releases
                // any held mispredict or stall is resolved exactly as in RUN.
                if ((state == S_RUN && mem_wait) || (state == S_MEM_WAIT && !DMEM_Ready)) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    if (state == S_RUN) begin
                        state_next = S_MEM_WAIT;
                        wait_next  = WAIT_LOAD;
                    end else if (wait_cnt == '0) begin
                        state_next = S_ERROR;
                    end else begin
                        wait_next = wait_cnt - 1'b1;
                    end
                end else begin
                    state_next = S_RUN;
                    wait_next  = '0;
                    if (Mispredict_EX) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                        state_next = S_FLUSH;
                    end else if (Stall) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (mem_wait) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    state_next   = S_MEM_WAIT;
                    wait_next    = WAIT_LOAD;
                end else begin
                    state_next = S_RUN;
                end
            end
            default: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end
        endcase

        stall_inc = !pc_en && (state != S_ERROR);
    end

    // Outputs are forced quiet while reset is held, independent of state.
    always_comb begin
        PC_EN        = rst_n & pc_en;
        IFID_EN      = rst_n & ifid_en;
        IDEX_EN      = rst_n & idex_en;
        EXMEM_EN     = rst_n & exmem_en;
        IFID_FLUSH   = rst_n & ifid_flush;
        IDEX_FLUSH   = rst_n & idex_flush;
        MEMWB_BUBBLE = rst_n & memwb_bubble;
    end

    assign State = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_inc && (StallCount != '1)) StallCount <= StallCount + 1'b1;
            if (flush_inc && (FlushCount != '1)) FlushCount <= FlushCount + 1'b1;
        end
    end

endmodule
